// File: rtl/queue_arbiter_pkg.sv
// ============================================================================
// queue_arbiter_pkg : shared types and default limits for queue_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package queue_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    GUARD    = 3'd3,
    ERROR    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ENQ_A = 2'd0,
    OP_ENQ_B = 2'd1,
    OP_DEQ   = 2'd2
  } op_t;

  localparam int unsigned FULL_LVL_DEF  = 7;
  localparam int unsigned GUARD_CYC_DEF = 3;
  localparam int unsigned TIMEOUT_DEF   = 15;

endpackage

`default_nettype wire

// File: rtl/queue_arbiter_rr_arb3.sv
// ============================================================================
// rr_arb3 : combinational 3-way round-robin picker (slot 0=A, 1=B, 2=DEQ)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb3 (
  input  logic [2:0] elig_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] win_o,
  output logic [1:0] ptr_nxt_o
);

  logic [5:0] w_dbl;
  logic [2:0] w_rot;
  logic [2:0] w_idx;

  // Doubling the vector turns the wrap-around search into a plain slice.
  assign w_dbl = {elig_i, elig_i};
  assign w_rot = w_dbl[ptr_i +: 3];

  always_comb begin
    win_o     = 3'b000;
    ptr_nxt_o = ptr_i;
    w_idx     = {1'b0, ptr_i};
    if (w_rot[0]) begin
      w_idx = {1'b0, ptr_i};
    end else if (w_rot[1]) begin
      w_idx = {1'b0, ptr_i} + 3'd1;
    end else begin
      w_idx = {1'b0, ptr_i} + 3'd2;
    end
    if (w_idx >= 3'd3) begin
      w_idx = w_idx - 3'd3;
    end
    if (|w_rot) begin
      win_o[w_idx[1:0]] = 1'b1;
      ptr_nxt_o         = (w_idx == 3'd2) ? 2'd0 : (w_idx[1:0] + 2'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/queue_arbiter.sv
// ============================================================================
// queue_arbiter : round-robin sequencer guarding an 8-entry byte queue
// Rev 1.0
// ============================================================================
`default_nettype none

module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int unsigned FULL_LVL  = FULL_LVL_DEF,
  parameter int unsigned GUARD_CYC = GUARD_CYC_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clock_10KHZ,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       grant_a,
  output logic       grant_b,
  input  logic       deq_req,
  output logic       deq_valid,
  output logic [7:0] deq_data,
  output logic       q_enqueue,
  output logic       q_dequeue,
  output logic [7:0] q_data_in,
  input  logic [3:0] q_len,
  input  logic [7:0] q_data_out,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] FULL_LVL_C  = FULL_LVL[3:0];
  localparam logic [3:0] GUARD_CYC_C = GUARD_CYC[3:0];
  localparam logic [4:0] TIMEOUT_C   = {1'b0, TIMEOUT[3:0]};

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] snap_q, snap_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] q_data_in_q, q_data_in_d;
  logic [7:0] deq_data_q, deq_data_d;
  logic       grant_a_q, grant_a_d;
  logic       grant_b_q, grant_b_d;
  logic       deq_valid_q, deq_valid_d;
  logic       q_enq_q, q_enq_d;
  logic       q_deq_q, q_deq_d;
  logic       err_q, err_d;

  logic [2:0] w_elig;
  logic [2:0] w_win;
  logic [1:0] w_ptr_nxt;
  logic [4:0] w_cnt_inc;

  assign full  = (q_len >= FULL_LVL_C);
  assign empty = (q_len == 4'd0);

  assign w_elig    = {deq_req & ~empty, req_b & ~full, req_a & ~full};
  assign w_cnt_inc = {1'b0, cnt_q} + 5'd1;

  rr_arb3 u_rr (
    .elig_i    (w_elig),
    .ptr_i     (ptr_q),
    .win_o     (w_win),
    .ptr_nxt_o (w_ptr_nxt)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ptr_d       = ptr_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    q_data_in_d = q_data_in_q;
    deq_data_d  = deq_data_q;
    grant_a_d   = 1'b0;
    grant_b_d   = 1'b0;
    deq_valid_d = 1'b0;
    q_enq_d     = 1'b0;
    q_deq_d     = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (|w_elig) begin
          state_d = ISSUE;
          ptr_d   = w_ptr_nxt;
          snap_d  = q_len;
          if (w_win[0]) begin
            op_d        = OP_ENQ_A;
            q_data_in_d = data_a;
            grant_a_d   = 1'b1;
            q_enq_d     = 1'b1;
          end else if (w_win[1]) begin
            op_d        = OP_ENQ_B;
            q_data_in_d = data_b;
            grant_b_d   = 1'b1;
            q_enq_d     = 1'b1;
          end else begin
            op_d    = OP_DEQ;
            q_deq_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = 4'd0;
      end
      WAIT_ACK: begin
        if (q_len != snap_q) begin
          state_d = GUARD;
          cnt_d   = GUARD_CYC_C;
          if (op_q == OP_DEQ) begin
            deq_data_d  = q_data_out;
            deq_valid_d = 1'b1;
          end
        end else if (w_cnt_inc >= TIMEOUT_C) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : w_cnt_inc[3:0];
        end
      end
      GUARD: begin
        // Leaving on the count of 1 yields exactly GUARD_CYC idle cycles.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ERROR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ENQ_A;
      ptr_q       <= 2'd0;
      snap_q      <= 4'd0;
      cnt_q       <= 4'd0;
      q_data_in_q <= 8'd0;
      deq_data_q  <= 8'd0;
      grant_a_q   <= 1'b0;
      grant_b_q   <= 1'b0;
      deq_valid_q <= 1'b0;
      q_enq_q     <= 1'b0;
      q_deq_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      q_data_in_q <= q_data_in_d;
      deq_data_q  <= deq_data_d;
      grant_a_q   <= grant_a_d;
      grant_b_q   <= grant_b_d;
      deq_valid_q <= deq_valid_d;
      q_enq_q     <= q_enq_d;
      q_deq_q     <= q_deq_d;
      err_q       <= err_d;
    end
  end

  assign grant_a   = grant_a_q;
  assign grant_b   = grant_b_q;
  assign deq_valid = deq_valid_q;
  assign deq_data  = deq_data_q;
  assign q_enqueue = q_enq_q;
  assign q_dequeue = q_deq_q;
  assign q_data_in = q_data_in_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_queue_arbiter.sv
// ============================================================================
// tb_queue_arbiter : directed bench for queue_arbiter with a small queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_queue_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, deq_req;
  logic [7:0] data_a, data_b;
  logic       grant_a, grant_b, deq_valid, q_enqueue, q_dequeue;
  logic [7:0] deq_data, q_data_in;
  logic [3:0] q_len;
  logic [7:0] q_data_out;
  logic       full, empty, busy, err;

  // Queue model: registered read data holds the popped byte.
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] mlen;
  logic       freeze, ovr_en;
  logic [3:0] ovr_len;

  int n_chk  = 0;
  int n_pass = 0;
  int na = 0, nb = 0, nenq = 0, ndeq = 0;

  always #5 clk = ~clk;

  assign q_len = ovr_en ? ovr_len : mlen;

  queue_arbiter dut (
    .clock_10KHZ (clk),
    .reset       (reset),
    .req_a       (req_a),
    .req_b       (req_b),
    .data_a      (data_a),
    .data_b      (data_b),
    .grant_a     (grant_a),
    .grant_b     (grant_b),
    .deq_req     (deq_req),
    .deq_valid   (deq_valid),
    .deq_data    (deq_data),
    .q_enqueue   (q_enqueue),
    .q_dequeue   (q_dequeue),
    .q_data_in   (q_data_in),
    .q_len       (q_len),
    .q_data_out  (q_data_out),
    .full        (full),
    .empty       (empty),
    .busy        (busy),
    .err         (err)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mlen       <= 4'd0;
      wp         <= 3'd0;
      rp         <= 3'd0;
      q_data_out <= 8'd0;
    end else if (!freeze) begin
      if (q_enqueue && mlen < 4'd8) begin
        mem[wp] <= q_data_in;
        wp      <= wp + 3'd1;
        mlen    <= mlen + 4'd1;
      end else if (q_dequeue && mlen > 4'd0) begin
        q_data_out <= mem[rp];
        rp         <= rp + 3'd1;
        mlen       <= mlen - 4'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (grant_a)   na   <= na + 1;
    if (grant_b)   nb   <= nb + 1;
    if (q_enqueue) nenq <= nenq + 1;
    if (q_dequeue) ndeq <= ndeq + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 grant_a, 1 grant_b, 2 deq_valid, 3 idle, 4 err, 5 any grant
  task automatic wait_for(input int which, input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      case (which)
        0: seen = grant_a;
        1: seen = grant_b;
        2: seen = deq_valid;
        3: seen = !busy;
        4: seen = err;
        default: seen = grant_a | grant_b;
      endcase
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int a0, b0, e0, d0;
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; deq_req = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    freeze = 1'b0; ovr_en = 1'b0; ovr_len = 4'd0;
    repeat (3) tick();
    chk("rst_outs", {grant_a, grant_b, deq_valid, q_enqueue, q_dequeue, busy, err}, 32'd0);
    chk("rst_data", {deq_data, q_data_in}, 32'd0);
    chk("rst_flags", {full, empty}, 32'b01);
    reset = 1'b1;
    tick();

    // Single enqueue of 3C, then drain it.
    a0 = na; e0 = nenq;
    data_a = 8'h3C; req_a = 1'b1;
    wait_for(0, 10, "grant_a_1");
    chk("enq_pulse_1", {31'd0, q_enqueue}, 32'd1);
    chk("q_data_in_1", {24'd0, q_data_in}, 32'h3C);
    chk("busy_1", {31'd0, busy}, 32'd1);
    req_a = 1'b0;
    tick();
    chk("pulse_drop_1", {grant_a, q_enqueue}, 32'd0);
    chk("q_data_in_hold", {24'd0, q_data_in}, 32'h3C);
    wait_for(3, 30, "idle_1");
    chk("grant_cnt_1", na - a0, 32'd1);
    chk("enq_cnt_1", nenq - e0, 32'd1);
    chk("len_1", {28'd0, q_len}, 32'd1);
    deq_req = 1'b1;
    wait_for(2, 30, "dv_1");
    deq_req = 1'b0;
    chk("deq_data_1", {24'd0, deq_data}, 32'h3C);
    tick();
    chk("dv_drop", {31'd0, deq_valid}, 32'd0);
    chk("deq_data_hold", {24'd0, deq_data}, 32'h3C);
    wait_for(3, 30, "idle_2");

    // Simultaneous producers: A then B, then FIFO order on dequeue.
    data_a = 8'h11; data_b = 8'h22; req_a = 1'b1; req_b = 1'b1;
    wait_for(5, 10, "grant_first");
    chk("first_is_a", {grant_a, grant_b}, 32'b10);
    chk("q_data_in_a", {24'd0, q_data_in}, 32'h11);
    req_a = 1'b0;
    wait_for(1, 30, "grant_b_2");
    chk("q_data_in_b", {24'd0, q_data_in}, 32'h22);
    req_b = 1'b0;
    wait_for(3, 30, "idle_3");
    chk("len_2", {28'd0, q_len}, 32'd2);
    deq_req = 1'b1;
    wait_for(2, 30, "dv_2");
    deq_req = 1'b0;
    chk("deq_data_11", {24'd0, deq_data}, 32'h11);
    wait_for(3, 30, "idle_4");
    deq_req = 1'b1;
    wait_for(2, 30, "dv_3");
    deq_req = 1'b0;
    chk("deq_data_22", {24'd0, deq_data}, 32'h22);
    wait_for(3, 30, "idle_5");

    // Full guard at the threshold and just below it.
    ovr_en = 1'b1; ovr_len = 4'd6;
    #1;
    chk("full_at_6", {31'd0, full}, 32'd0);
    ovr_len = 4'd7;
    #1;
    chk("full_at_7", {31'd0, full}, 32'd1);
    a0 = na; e0 = nenq;
    req_a = 1'b1;
    repeat (50) tick();
    chk("full_no_grant", na - a0, 32'd0);
    chk("full_no_enq", nenq - e0, 32'd0);
    req_a = 1'b0; ovr_en = 1'b0;
    tick();

    // Empty guard, then an enqueue unblocks the waiting dequeue.
    d0 = ndeq;
    deq_req = 1'b1;
    repeat (20) tick();
    chk("empty_no_deq", ndeq - d0, 32'd0);
    chk("empty_flag", {31'd0, empty}, 32'd1);
    data_a = 8'hA5; req_a = 1'b1;
    wait_for(0, 10, "grant_a5");
    req_a = 1'b0;
    wait_for(2, 40, "dv_a5");
    deq_req = 1'b0;
    chk("deq_data_a5", {24'd0, deq_data}, 32'hA5);
    wait_for(3, 30, "idle_6");

    // Stuck queue: timeout into sticky error, no further grants.
    freeze = 1'b1;
    data_a = 8'h77; req_a = 1'b1;
    wait_for(0, 10, "grant_77");
    req_a = 1'b0;
    wait_for(4, 40, "err_set");
    chk("err_busy", {31'd0, busy}, 32'd1);
    a0 = na; b0 = nb; e0 = nenq;
    req_b = 1'b1;
    repeat (30) tick();
    chk("err_no_grant", (na - a0) + (nb - b0), 32'd0);
    chk("err_no_enq", nenq - e0, 32'd0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    req_b = 1'b0;
    reset = 1'b0;
    tick();
    chk("err_cleared", {31'd0, err}, 32'd0);
    reset = 1'b1; freeze = 1'b0;
    tick();

    // Asynchronous reset during WAIT_ACK, pointer returns to A.
    freeze = 1'b1;
    data_a = 8'h5A; req_a = 1'b1;
    wait_for(0, 10, "grant_5a");
    req_a = 1'b0;
    tick();
    tick();
    chk("in_wait_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_outs", {grant_a, grant_b, deq_valid, q_enqueue, q_dequeue, busy, err}, 32'd0);
    chk("async_data", {deq_data, q_data_in}, 32'd0);
    #2 reset = 1'b1;
    freeze = 1'b0;
    tick();
    data_a = 8'h01; data_b = 8'h02; req_a = 1'b1; req_b = 1'b1;
    wait_for(5, 10, "grant_after_rst");
    chk("ptr_reset_a", {grant_a, grant_b}, 32'b10);
    req_a = 1'b0;
    wait_for(1, 30, "grant_b_after_rst");
    req_b = 1'b0;
    wait_for(3, 30, "idle_7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/queue_arbiter.md
# queue_arbiter

Sequencer and arbiter in front of the 8-entry byte queue. Two producers (A, B) and one consumer share the queue. The block round-robins their requests, issues single-cycle enqueue/dequeue commands, and detects completion by watching the queue's length output. It enforces the full/empty guards the queue lacks and flags a stuck queue.

## Interface
Parameters:
- FULL_LVL, 7: queue counts as full when q_len ≥ FULL_LVL; no enqueue is issued at or above it.
- GUARD_CYC, 3: idle cycles after each completed command before the next issue.
- TIMEOUT, 15: cycles in WAIT_ACK without a q_len change before entering ERROR.

Ports:
- clock_10KHZ  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- req_a / req_b  in  1  producer enqueue request level; held until grant.
- data_a / data_b  in  8  producer byte, sampled on the grant edge.
- grant_a / grant_b  out  1  one-cycle pulse: request accepted, data captured.
- deq_req  in  1  consumer dequeue request level; held until deq_valid.
- deq_valid  out  1  one-cycle pulse: deq_data holds the dequeued byte.
- deq_data  out  8  dequeued byte; holds its value until the next dequeue.
- q_enqueue / q_dequeue  out  1  one-cycle command pulses to the queue.
- q_data_in  out  8  byte to enqueue; stable from ISSUE through completion.
- q_len  in  4  queue occupancy.
- q_data_out  in  8  queue head output.
- full / empty  out  1  combinational from q_len: ≥FULL_LVL, ==0.
- busy  out  1  state ≠ IDLE.
- err  out  1  sticky; high in ERROR.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, GUARD, ERROR.
- Eligibility is evaluated in IDLE only:
  - A is eligible when req_a && !full; B likewise.
  - DEQ is eligible when deq_req && !empty.
- Round-robin order is A→B→DEQ→A. Pointer starts at A after reset. Search begins at the pointer; the first eligible requester wins. Pointer then moves to the slot after the winner.
- IDLE → ISSUE when any requester is eligible. On the same edge:
  - latch op and snapshot len ← q_len;
  - for enqueue, q_data_in ← data_x and the matching grant_x pulses;
  - assert q_enqueue or q_dequeue.
- ISSUE → WAIT_ACK unconditionally. The command pulse drops and the timeout counter clears.
- WAIT_ACK, when q_len ≠ snapshot → GUARD, with the guard counter loaded to GUARD_CYC. For DEQ on that edge, deq_data ← q_data_out and deq_valid pulses.
- WAIT_ACK, when the counter reaches TIMEOUT with q_len unchanged → ERROR.
- GUARD counts down to 0, then → IDLE.
- ERROR is absorbing. No commands are issued and no grants are given; only reset exits.
- A dequeue is never issued at q_len=0, and an enqueue is never issued at q_len ≥ FULL_LVL. Both conditions would hang or corrupt the queue.
- Dropping a request before its grant simply withdraws it. After acceptance the operation completes regardless of the request level.

## Timing
- Reset values:
  - outputs: grants, deq_valid, deq_data, q_enqueue, q_dequeue, q_data_in, busy and err all 0;
  - state: IDLE, rr pointer = A, counters 0.
- Command latency: a request seen in IDLE at edge k gives grant (enqueue) and q_* pulse high for the cycle after edge k only.
- Completion:
  - detected on the first edge where q_len differs from the snapshot;
  - deq_valid is high for exactly one cycle after that edge.
- Minimum spacing between issued commands = 2 + ack latency + GUARD_CYC cycles.
- Simultaneous requests: one grant per command, chosen by round-robin. Losers keep waiting with no data loss, since producers hold their data until granted.
- Reset asserted mid-operation: immediate return to the reset state. The queue must share the same reset event, i.e. this block's reset inverted drives the queue's reset.
- Counters are 4-bit and saturate. TIMEOUT and GUARD_CYC must be ≤15.

## Structure
- queue_arbiter_pkg holds:
  - state_t {IDLE, ISSUE, WAIT_ACK, GUARD, ERROR};
  - op_t {OP_ENQ_A, OP_ENQ_B, OP_DEQ};
  - default constants for FULL_LVL, GUARD_CYC, TIMEOUT.
- Sub-module rr_arb3: 3-request round-robin picker. Inputs are the eligibility vector and the pointer. Outputs are a one-hot winner and the next pointer. It is purely combinational, with the pointer register living in queue_arbiter.
- The top level contains the FSM, snapshot, counters and output registers.

## Test plan
- Reset, then req_a with data_a=8'h3C: grant_a pulses once and q_enqueue pulses once with q_data_in=8'h3C. Model len 0→1 gives busy for 2+ack+3 cycles, then IDLE.
- req_a and req_b held together with 8'h11/8'h22, queue empty: grants go A then B. Then deq_req gives deq_valid with deq_data=8'h11, and a second dequeue gives 8'h22.
- q_len=7 with req_a held: no grant and no q_enqueue over 50 cycles. full=1.
- q_len=0 with deq_req held: q_dequeue is never asserted and empty=1. After an enqueue of 8'hA5 the dequeue proceeds and returns 8'hA5.
- Model queue ignores the command (q_len frozen): after TIMEOUT cycles err=1, and later requests get no grants. reset low then high clears err.
- Reset pulsed low during WAIT_ACK: all outputs drop to 0 asynchronously before the next edge, and the arbiter is back in IDLE with the pointer at A.
